disp_source_scheduler: RTL

- Shares the 4-digit seven-segment display between four data sources (steps, distance, activity time, stopwatch).
- Rotates round-robin among the sources whose valid is high, dwelling a fixed time on each.
- Generates the digit-scan strobe for the display driver and presents a frame-consistent 28-bit segment word.
- Sits between the source formatters and the digit-multiplexing display driver, which advances one digit per `scan_tick`.

---
 rtl/disp_pkg.sv | 14 +
 rtl/disp_scan_timer.sv | 46 ++++
 rtl/disp_source_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants and types for the display source scheduler.
package disp_pkg;

    localparam int          NUM_SRC     = 4;
    localparam logic [6:0]  BLANK_DIGIT = 7'h7F;
    localparam logic [27:0] BLANK_WORD  = {4{BLANK_DIGIT}};

    typedef enum logic [1:0] {
        BLANK     = 2'd0,
        SHOW      = 2'd1,
        SWAP_WAIT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/disp_scan_timer.sv
// Digit-scan timebase: prescaler producing one scan_tick per digit slot and
// a digit index that marks the last slot of each 4-digit frame.
module disp_scan_timer #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic scan_tick,
    output logic frame_end
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic             scan_tick_q, scan_tick_d;

    // Next values: prescaler wraps at SCAN_DIV-1; the tick flop is high
    // exactly while the prescaler sits on its last count.
    always_comb begin
        div_cnt_d   = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        scan_tick_d = (div_cnt_d == DIV_LAST);
        digit_idx_d = scan_tick_q ? digit_idx_q + 2'd1 : digit_idx_q;
    end

    // Timebase registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            digit_idx_q <= 2'd0;
            scan_tick_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            scan_tick_q <= scan_tick_d;
        end
    end

    // Outputs: the frame ends on the tick of the last digit slot.
    always_comb begin
        scan_tick = scan_tick_q;
        frame_end = scan_tick_q && (digit_idx_q == 2'd3);
    end

endmodule

// File: rtl/disp_source_scheduler.sv
// Round-robin scheduler sharing one 4-digit seven-segment display between
// four sources. Source switches and data snapshots happen only at frame
// boundaries so the display driver never mixes two words in one frame.
// Optional feature macro: DISP_SCHED_FORCE_EN adds force_req/force_sel to
// pin the display to one source.
module disp_source_scheduler #(
    parameter int SCAN_DIV     = 100000,
    parameter int DWELL_CYCLES = 200000000
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef DISP_SCHED_FORCE_EN
    input  logic         force_req,
    input  logic [1:0]   force_sel,
`endif
    input  logic [3:0]   src_valid,
    input  logic [111:0] src_data,
    input  logic         hold,
    output logic [27:0]  sev_seg_data,
    output logic         scan_tick,
    output logic [1:0]   src_sel,
    output logic         blanked,
    output logic [1:0]   state_dbg
);
    import disp_pkg::*;

    localparam int              DW_W       = $clog2(DWELL_CYCLES);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

    // Returns {found, index} of the first valid source after cur, wrapping
    // around; cur itself is the last candidate so a lone source is kept.
    function automatic logic [2:0] next_src(input logic [3:0] valid,
                                            input logic [1:0] cur);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (valid[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    function automatic logic [27:0] src_word(input logic [111:0] data,
                                             input logic [1:0]   idx);
        return data[28*idx +: 28];
    endfunction

    logic         frame_end;
    logic         force_active;
    logic [1:0]   force_idx;

    sched_state_t    state_q, state_d;
    logic [1:0]      src_sel_q, src_sel_d;
    logic [27:0]     sev_seg_q, sev_seg_d;
    logic [DW_W-1:0] dwell_q, dwell_d;

    logic [2:0]      nxt;
    logic            cur_valid;
    logic            dwell_sat;

    disp_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_tick (scan_tick),
        .frame_end (frame_end)
    );

`ifdef DISP_SCHED_FORCE_EN
    assign force_active = force_req;
    assign force_idx    = force_sel;
`else
    assign force_active = 1'b0;
    assign force_idx    = 2'd0;
`endif

    // State register: FSM state, selected source, segment snapshot, dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BLANK;
            src_sel_q <= 2'd0;
            sev_seg_q <= BLANK_WORD;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_sel_q <= src_sel_d;
            sev_seg_q <= sev_seg_d;
            dwell_q   <= dwell_d;
        end
    end

    // Next state: invalid current source beats hold; hold only defers a
    // dwell-driven rotation, and the snapshot refreshes on every frame.
    always_comb begin
        state_d   = state_q;
        src_sel_d = src_sel_q;
        sev_seg_d = sev_seg_q;
        dwell_d   = dwell_q;
        nxt       = next_src(src_valid, src_sel_q);
        cur_valid = src_valid[src_sel_q];
        dwell_sat = (dwell_q == DWELL_LAST);

        if (force_active) begin
            dwell_d = '0;
            if (frame_end) begin
                if (src_valid[force_idx]) begin
                    state_d   = SHOW;
                    src_sel_d = force_idx;
                    sev_seg_d = src_word(src_data, force_idx);
                end else begin
                    state_d   = BLANK;
                    sev_seg_d = BLANK_WORD;
                end
            end
        end else begin
            case (state_q)
                BLANK: begin
                    if (frame_end && nxt[2]) begin
                        state_d   = SHOW;
                        src_sel_d = nxt[1:0];
                        sev_seg_d = src_word(src_data, nxt[1:0]);
                        dwell_d   = '0;
                    end
                end
                SHOW: begin
                    if (frame_end) begin
                        if (!cur_valid || (dwell_sat && !hold)) begin
                            dwell_d = '0;
                            if (nxt[2]) begin
                                src_sel_d = nxt[1:0];
                                sev_seg_d = src_word(src_data, nxt[1:0]);
                            end else begin
                                state_d   = BLANK;
                                sev_seg_d = BLANK_WORD;
                            end
                        end else begin
                            sev_seg_d = src_word(src_data, src_sel_q);
                            if (!hold && !dwell_sat) dwell_d = dwell_q + DW_W'(1);
                        end
                    end else if (dwell_sat) begin
                        state_d = SWAP_WAIT;
                    end else if (!hold) begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
                SWAP_WAIT: begin
                    if (frame_end) begin
                        state_d = SHOW;
                        if (!cur_valid || !hold) begin
                            dwell_d = '0;
                            if (nxt[2]) begin
                                src_sel_d = nxt[1:0];
                                sev_seg_d = src_word(src_data, nxt[1:0]);
                            end else begin
                                state_d   = BLANK;
                                sev_seg_d = BLANK_WORD;
                            end
                        end else begin
                            sev_seg_d = src_word(src_data, src_sel_q);
                        end
                    end
                end
                default: begin
                    state_d   = BLANK;
                    sev_seg_d = BLANK_WORD;
                    dwell_d   = '0;
                end
            endcase
        end
    end

    // Outputs straight from registers.
    always_comb begin
        sev_seg_data = sev_seg_q;
        src_sel      = src_sel_q;
        blanked      = (state_q == BLANK);
        state_dbg    = state_q;
    end

endmodule
